sram_sp_ctrl: RTL and testbench
===============================

# sram_sp_ctrl

Parametrised single-port SRAM controller that replaces the fixed-size 32-bit SRAM black boxes (1024/2048/3072/4096 words) with one block generic in width and depth. It adds a valid/ready request port, byte-enable writes, an optional registered read output and a power-on clear sequence. It sits between accelerator datapaths and on-chip buffer storage. The storage array is a separate sub-module so that an FPGA behavioural array or an ASIC macro can be bound underneath without changing the controller.

## Interface
- `WIDTH`, 32: data width in bits; must be a multiple of 8.
- `DEPTH`, 4096: number of words; any value ≥ 2, not necessarily a power of two (e.g. 3072).
- `OUT_REG`, 0: 0 gives 1-cycle read latency; 1 adds an output register for 2-cycle latency.
- `INIT_VAL`, 0: WIDTH-bit value written to every word by the clear sequence.
- `AW` (derived, `$clog2(DEPTH)`): address width.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `stdby`  in  1  standby request; blocks new requests while high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  AW  word address.
- `req_be`  in  WIDTH/8  byte enables, used for writes only.
- `req_wdata`  in  WIDTH  write data.
- `rsp_valid`  out  1  read data valid, one-cycle pulse per accepted read.
- `rsp_rdata`  out  WIDTH  read data.
- `rsp_err`  out  1  qualifies `rsp_valid`; set when the read address was ≥ DEPTH.
- `init_done`  out  1  high once the clear sequence has completed.

## Operation
- **States:**
  - CLEAR: entered on reset. Holds a counter `clr_addr` that starts at 0 and writes `INIT_VAL` with all byte enables set, one word per cycle. When `clr_addr == DEPTH-1` is written, the FSM moves to RUN.
  - RUN: normal operation.
  - STBY: entered from RUN when `stdby` is high. Returns to RUN in the first cycle that `stdby` is low.
- `req_ready` is high only in RUN with `stdby` low. It is combinational from state and `stdby`, not from `req_valid`.
- **Accepted write:** bytes with `req_be[i]=1` are updated and all other bytes are kept. A write to an address ≥ DEPTH is dropped silently and produces no response.
- **Accepted read:** returns the word at `req_addr`. An address ≥ DEPTH returns all-zero data with `rsp_err=1`.
- One operation per cycle; this is a single port. A write followed next cycle by a read of the same address returns the new data.
- The response path has no backpressure; the consumer must always sink `rsp_valid`.
- Requests already in flight when `stdby` rises still complete and produce their responses.
- **Reset outputs:**
  - `req_ready=0`, `rsp_valid=0`, `rsp_err=0`, `rsp_rdata=0`, `init_done=0`.
  - `rsp_rdata` holds its last value when `rsp_valid=0`.
- **Reset mid-operation:** in-flight read responses are discarded, the pipeline is flushed and CLEAR restarts from address 0. Memory contents are unspecified until `init_done` rises again.

## Timing
- Clear sequence lasts exactly DEPTH cycles after `rst_n` is sampled high.
  - `init_done` and `req_ready` rise in cycle DEPTH+1.
  - Example: DEPTH=3072 means the first request is accepted in cycle 3073.
- **Read latency:** request accepted in cycle N gives `rsp_valid` in cycle N+1 when OUT_REG=0, or N+2 when OUT_REG=1.
- Throughput is one request per cycle, reads and writes back-to-back with no bubbles.
- Write data is visible to a read accepted in the following cycle.
- If `stdby` rises in cycle N, `req_ready` is low in cycle N. Responses already in flight still appear at N+1 (and N+2 with OUT_REG=1).

## Structure
- **Package `sram_pkg`:**
  - state enum `sram_state_e` {CLEAR, RUN, STBY}.
  - a `be_expand` function that turns byte enables into a bit mask.
- **Sub-module `sram_sp_array`:** parameters WIDTH and DEPTH. Ports `clk`, `en`, `we`, `addr`, `bmask`, `wdata`, `rdata`. Synchronous read with one-cycle latency and no reset on the storage. This is the only module replaced by a vendor macro.
- **Controller:** the FSM, the clear counter, the address-range check, response valid/err tracking and the optional output register.

## Test plan
- **Clear sequence:** WIDTH=32, DEPTH=3072, INIT_VAL=32'hA5A5_A5A5. Release reset, then read addresses 0, 1535 and 3071 → `init_done` rises in cycle 3073 and all three reads return A5A5_A5A5 with `rsp_err=0`.
- **Byte-enable write:** write 0xDEADBEEF at address 7 with be=4'hF, then 0x00001122 with be=4'b0011, then read address 7 → 0xDEAD1122 in cycle N+1 (OUT_REG=0).
- **Back-to-back pipeline:** OUT_REG=1, 8 consecutive reads of addresses 0–7 previously written with address×3 → `rsp_valid` high for 8 consecutive cycles starting at N+2, data 0, 3, …, 21.
- **Out of range:** DEPTH=3072, read address 3072 → `rsp_rdata=0`, `rsp_err=1`. Write to address 4000, then read address 0 → address 0 unchanged.
- **Standby:** assert `stdby` for 5 cycles with `req_valid` held high and one read in flight → `req_ready=0` for 5 cycles, the in-flight response still arrives, and the held request is accepted in the first cycle after `stdby` falls.
- **Reset mid-read:** pull `rst_n` low in the cycle after a read is accepted → no `rsp_valid` appears, `init_done=0`, and CLEAR reruns for DEPTH cycles.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and helpers for the single-port SRAM controller.
package sram_pkg;

    // Controller operating states.
    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        STBY  = 2'd2
    } sram_state_e;

    // Expands one byte-enable bit into the 8-bit mask for its byte lane.
    function automatic logic [7:0] be_expand(input logic be);
        return {8{be}};
    endfunction

endpackage

// File: rtl/sram_sp_array.sv
// Behavioural single-port storage array: synchronous read, one-cycle latency,
// bit-masked writes, no reset on the storage. A vendor macro binds here.
module sram_sp_array #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4096,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_en,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_bmask,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Masked write or registered read of one word per enabled cycle.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= (r_mem[i_addr] & ~i_bmask) | (i_wdata & i_bmask);
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sram_sp_ctrl.sv
// Single-port SRAM controller: power-on clear, valid/ready request port,
// byte-enable writes, range checking and optional registered read output.
module sram_sp_ctrl
    import sram_pkg::*;
#(
    parameter  int               WIDTH    = 32,
    parameter  int               DEPTH    = 4096,
    parameter  int               OUT_REG  = 0,
    parameter  logic [WIDTH-1:0] INIT_VAL = '0,
    localparam int               AW       = $clog2(DEPTH),
    localparam int               NB       = WIDTH / 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_stdby,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic             i_req_we,
    input  logic [AW-1:0]    i_req_addr,
    input  logic [NB-1:0]    i_req_be,
    input  logic [WIDTH-1:0] i_req_wdata,
    output logic             o_rsp_valid,
    output logic [WIDTH-1:0] o_rsp_rdata,
    output logic             o_rsp_err,
    output logic             o_init_done
);

    sram_state_e      r_state;
    sram_state_e      w_state_nxt;
    logic [AW-1:0]    r_clr_addr;
    logic             w_clearing;
    logic             w_ready;
    logic             w_acc;
    logic             w_rd_acc;
    logic             w_in_range;
    logic [WIDTH-1:0] w_req_bmask;
    logic             w_arr_en;
    logic             w_arr_we;
    logic [AW-1:0]    w_arr_addr;
    logic [WIDTH-1:0] w_arr_bmask;
    logic [WIDTH-1:0] w_arr_wdata;
    logic [WIDTH-1:0] w_arr_rdata;
    logic             r_vld_p1;
    logic             r_err_p1;
    logic             w_rsp_vld_p1;
    logic [WIDTH-1:0] w_data_p1;

    // State register; reset restarts the clear sequence.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and ready. Leaving STBY happens in the same cycle stdby drops,
    // so that cycle already accepts a held request.
    always_comb begin
        w_state_nxt = r_state;
        w_clearing  = 1'b0;
        w_ready     = 1'b0;
        case (r_state)
            CLEAR: begin
                w_clearing = 1'b1;
                if (r_clr_addr == AW'(DEPTH - 1)) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (i_stdby) begin
                    w_state_nxt = STBY;
                end else begin
                    w_ready = 1'b1;
                end
            end
            STBY: begin
                if (!i_stdby) begin
                    w_state_nxt = RUN;
                    w_ready     = 1'b1;
                end
            end
            default: w_state_nxt = CLEAR;
        endcase
    end

    // Clear address walks 0..DEPTH-1, one word per cycle while clearing.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_clr_addr <= '0;
        end else if (w_clearing) begin
            r_clr_addr <= r_clr_addr + AW'(1);
        end
    end

    assign o_req_ready = w_ready;
    assign o_init_done = (r_state != CLEAR);
    assign w_acc       = i_req_valid & w_ready;
    assign w_rd_acc    = w_acc & ~i_req_we;
    assign w_in_range  = (32'(i_req_addr) < 32'(DEPTH));

    for (genvar gi = 0; gi < NB; gi++) begin : g_be
        assign w_req_bmask[8*gi +: 8] = be_expand(i_req_be[gi]);
    end

    // Array port mux: clear writes take the port, otherwise in-range requests.
    always_comb begin
        w_arr_en    = 1'b0;
        w_arr_we    = 1'b0;
        w_arr_addr  = i_req_addr;
        w_arr_bmask = w_req_bmask;
        w_arr_wdata = i_req_wdata;
        if (w_clearing) begin
            w_arr_en    = 1'b1;
            w_arr_we    = 1'b1;
            w_arr_addr  = r_clr_addr;
            w_arr_bmask = '1;
            w_arr_wdata = INIT_VAL;
        end else if (w_acc && w_in_range) begin
            w_arr_en = 1'b1;
            w_arr_we = i_req_we;
        end
    end

    sram_sp_array #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_array (
        .i_clk   (i_clk),
        .i_en    (w_arr_en),
        .i_we    (w_arr_we),
        .i_addr  (w_arr_addr),
        .i_bmask (w_arr_bmask),
        .i_wdata (w_arr_wdata),
        .o_rdata (w_arr_rdata)
    );

    // Stage p1: array data arrives; track which reads respond and which erred.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_vld_p1 <= 1'b0;
            r_err_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= w_rd_acc;
            r_err_p1 <= ~w_in_range;
        end
    end

    // A response pending while reset is asserted is discarded, not presented.
    assign w_rsp_vld_p1 = r_vld_p1 & i_rst_n;
    assign w_data_p1    = r_err_p1 ? '0 : w_arr_rdata;

    if (OUT_REG != 0) begin : g_oreg
        logic             r_vld_p2;
        logic             r_err_p2;
        logic [WIDTH-1:0] r_rdata_p2;

        // Stage p2: output register, data held between responses.
        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                r_vld_p2   <= 1'b0;
                r_err_p2   <= 1'b0;
                r_rdata_p2 <= '0;
            end else begin
                r_vld_p2 <= w_rsp_vld_p1;
                r_err_p2 <= w_rsp_vld_p1 & r_err_p1;
                if (w_rsp_vld_p1) begin
                    r_rdata_p2 <= w_data_p1;
                end
            end
        end

        assign o_rsp_valid = r_vld_p2 & i_rst_n;
        assign o_rsp_err   = r_err_p2 & i_rst_n;
        assign o_rsp_rdata = r_rdata_p2;
    end else begin : g_noreg
        logic [WIDTH-1:0] r_last;

        // Keeps the last returned word so rdata holds between responses.
        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                r_last <= '0;
            end else if (w_rsp_vld_p1) begin
                r_last <= w_data_p1;
            end
        end

        assign o_rsp_valid = w_rsp_vld_p1;
        assign o_rsp_err   = w_rsp_vld_p1 & r_err_p1;
        assign o_rsp_rdata = w_rsp_vld_p1 ? w_data_p1 : r_last;
    end

endmodule

// File: tb/tb_sram_sp_ctrl.sv
// Directed bench: instance A (DEPTH=3072, OUT_REG=0, INIT A5A5A5A5) and
// instance B (DEPTH=12, OUT_REG=1, INIT 0).
module tb_sram_sp_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A signals
    logic        a_rst_n, a_stdby, a_valid, a_we, a_ready;
    logic [11:0] a_addr;
    logic [3:0]  a_be;
    logic [31:0] a_wdata, a_rdata;
    logic        a_rsp_valid, a_rsp_err, a_init_done;

    // Instance B signals
    logic        b_rst_n, b_stdby, b_valid, b_we, b_ready;
    logic [3:0]  b_addr;
    logic [3:0]  b_be;
    logic [31:0] b_wdata, b_rdata;
    logic        b_rsp_valid, b_rsp_err, b_init_done;

    sram_sp_ctrl #(
        .WIDTH(32), .DEPTH(3072), .OUT_REG(0), .INIT_VAL(32'hA5A5_A5A5)
    ) dut_a (
        .i_clk(clk), .i_rst_n(a_rst_n), .i_stdby(a_stdby),
        .i_req_valid(a_valid), .o_req_ready(a_ready), .i_req_we(a_we),
        .i_req_addr(a_addr), .i_req_be(a_be), .i_req_wdata(a_wdata),
        .o_rsp_valid(a_rsp_valid), .o_rsp_rdata(a_rdata), .o_rsp_err(a_rsp_err),
        .o_init_done(a_init_done)
    );

    sram_sp_ctrl #(
        .WIDTH(32), .DEPTH(12), .OUT_REG(1), .INIT_VAL(32'h0)
    ) dut_b (
        .i_clk(clk), .i_rst_n(b_rst_n), .i_stdby(b_stdby),
        .i_req_valid(b_valid), .o_req_ready(b_ready), .i_req_we(b_we),
        .i_req_addr(b_addr), .i_req_be(b_be), .i_req_wdata(b_wdata),
        .o_rsp_valid(b_rsp_valid), .o_rsp_rdata(b_rdata), .o_rsp_err(b_rsp_err),
        .o_init_done(b_init_done)
    );

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        rv;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    localparam int NA = 18;
    vec_t va [NA];

    function automatic vec_t row(input logic we, input logic [11:0] addr,
                                 input logic [3:0] be, input logic [31:0] wdata,
                                 input logic rv, input logic [31:0] rdata,
                                 input logic err);
        vec_t v;
        v.we = we; v.addr = addr; v.be = be; v.wdata = wdata;
        v.rv = rv; v.rdata = rdata; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a_last;
        logic [31:0] b_exp;

        va[0]  = row(0, 12'd0,    4'h0, 32'h0,         1, 32'hA5A5_A5A5, 0);
        va[1]  = row(0, 12'd1535, 4'h0, 32'h0,         1, 32'hA5A5_A5A5, 0);
        va[2]  = row(0, 12'd3071, 4'h0, 32'h0,         1, 32'hA5A5_A5A5, 0);
        va[3]  = row(1, 12'd7,    4'hF, 32'hDEAD_BEEF, 0, 32'h0,         0);
        va[4]  = row(1, 12'd7,    4'h3, 32'h0000_1122, 0, 32'h0,         0);
        va[5]  = row(0, 12'd7,    4'h0, 32'h0,         1, 32'hDEAD_1122, 0);
        va[6]  = row(0, 12'd3072, 4'h0, 32'h0,         1, 32'h0,         1);
        va[7]  = row(1, 12'd4000, 4'hF, 32'h1234_5678, 0, 32'h0,         0);
        va[8]  = row(0, 12'd0,    4'h0, 32'h0,         1, 32'hA5A5_A5A5, 0);
        va[9]  = row(1, 12'd5,    4'h8, 32'h1122_3344, 0, 32'h0,         0);
        va[10] = row(0, 12'd5,    4'h0, 32'h0,         1, 32'h11A5_A5A5, 0);
        va[11] = row(1, 12'd6,    4'h4, 32'hFFFF_FFFF, 0, 32'h0,         0);
        va[12] = row(0, 12'd6,    4'h0, 32'h0,         1, 32'hA5FF_A5A5, 0);
        va[13] = row(0, 12'd4095, 4'h0, 32'h0,         1, 32'h0,         1);
        va[14] = row(1, 12'd3071, 4'h0, 32'h0,         0, 32'h0,         0);
        va[15] = row(0, 12'd3071, 4'h0, 32'h0,         1, 32'hA5A5_A5A5, 0);
        va[16] = row(1, 12'd9,    4'h6, 32'hCAFE_F00D, 0, 32'h0,         0);
        va[17] = row(0, 12'd9,    4'h0, 32'h0,         1, 32'hA5FE_F0A5, 0);

        a_rst_n = 0; a_stdby = 0; a_valid = 0; a_we = 0; a_addr = '0; a_be = '0; a_wdata = '0;
        b_rst_n = 0; b_stdby = 0; b_valid = 0; b_we = 0; b_addr = '0; b_be = '0; b_wdata = '0;
        a_last = 32'h0;

        // Reset state of both instances
        repeat (3) @(negedge clk);
        #1;
        chk("a_rst_ready", 32'(a_ready), 0);
        chk("a_rst_valid", 32'(a_rsp_valid), 0);
        chk("a_rst_err", 32'(a_rsp_err), 0);
        chk("a_rst_rdata", a_rdata, 32'h0);
        chk("a_rst_init_done", 32'(a_init_done), 0);
        chk("b_rst_ready", 32'(b_ready), 0);
        chk("b_rst_valid", 32'(b_rsp_valid), 0);
        chk("b_rst_rdata", b_rdata, 32'h0);
        chk("b_rst_init_done", 32'(b_init_done), 0);

        // A: clear sequence, first request cycle is 3073
        @(negedge clk);
        a_rst_n = 1;
        #1;
        chk("a_clr_c1_ready", 32'(a_ready), 0);
        repeat (3071) @(negedge clk);
        #1;
        chk("a_clr_c3072_init_done", 32'(a_init_done), 0);
        chk("a_clr_c3072_ready", 32'(a_ready), 0);

        // A: table vectors, response of row i-1 checked in cycle of row i
        for (int i = 0; i <= NA; i++) begin
            @(negedge clk);
            if (i < NA) begin
                a_valid = 1; a_we = va[i].we; a_addr = va[i].addr;
                a_be = va[i].be; a_wdata = va[i].wdata;
            end else begin
                a_valid = 0; a_we = 0;
            end
            #1;
            if (i == 0) chk("a_init_done_c3073", 32'(a_init_done), 1);
            if (i < NA) chk($sformatf("a_ready_r%0d", i), 32'(a_ready), 1);
            if (i > 0) begin
                chk($sformatf("a_valid_r%0d", i-1), 32'(a_rsp_valid), 32'(va[i-1].rv));
                if (va[i-1].rv) begin
                    chk($sformatf("a_rdata_r%0d", i-1), a_rdata, va[i-1].rdata);
                    chk($sformatf("a_err_r%0d", i-1), 32'(a_rsp_err), 32'(va[i-1].err));
                    a_last = va[i-1].rdata;
                end else begin
                    chk($sformatf("a_hold_r%0d", i-1), a_rdata, a_last);
                end
            end
        end

        // A: standby with one read in flight and a request held
        @(negedge clk);
        a_valid = 1; a_we = 0; a_addr = 12'd7;
        #1;
        chk("a_stby_c0_ready", 32'(a_ready), 1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            a_stdby = 1; a_valid = 1; a_addr = 12'd5;
            #1;
            chk($sformatf("a_stby_c%0d_ready", k), 32'(a_ready), 0);
            chk($sformatf("a_stby_c%0d_init", k), 32'(a_init_done), 1);
            if (k == 1) begin
                chk("a_stby_inflight_valid", 32'(a_rsp_valid), 1);
                chk("a_stby_inflight_rdata", a_rdata, 32'hDEAD_1122);
            end else begin
                chk($sformatf("a_stby_c%0d_valid", k), 32'(a_rsp_valid), 0);
            end
        end
        @(negedge clk);
        a_stdby = 0;
        #1;
        chk("a_stby_release_ready", 32'(a_ready), 1);
        chk("a_stby_release_valid", 32'(a_rsp_valid), 0);
        @(negedge clk);
        a_valid = 0;
        #1;
        chk("a_stby_held_valid", 32'(a_rsp_valid), 1);
        chk("a_stby_held_rdata", a_rdata, 32'h11A5_A5A5);
        chk("a_stby_held_err", 32'(a_rsp_err), 0);

        // A: reset in the cycle after a read is accepted
        @(negedge clk);
        a_valid = 1; a_we = 0; a_addr = 12'd7;
        #1;
        chk("a_rr_accept_ready", 32'(a_ready), 1);
        @(negedge clk);
        a_valid = 0; a_rst_n = 0;
        #1;
        chk("a_rr_c1_valid", 32'(a_rsp_valid), 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("a_rr_hold%0d_valid", k), 32'(a_rsp_valid), 0);
            chk($sformatf("a_rr_hold%0d_init", k), 32'(a_init_done), 0);
            chk($sformatf("a_rr_hold%0d_ready", k), 32'(a_ready), 0);
            chk($sformatf("a_rr_hold%0d_rdata", k), a_rdata, 32'h0);
        end
        @(negedge clk);
        a_rst_n = 1;
        #1;
        repeat (3071) @(negedge clk);
        #1;
        chk("a_rr_c3072_init_done", 32'(a_init_done), 0);
        @(negedge clk);
        a_valid = 1; a_we = 0; a_addr = 12'd7;
        #1;
        chk("a_rr_c3073_init_done", 32'(a_init_done), 1);
        chk("a_rr_c3073_ready", 32'(a_ready), 1);
        @(negedge clk);
        a_valid = 0;
        #1;
        chk("a_rr_reclear_valid", 32'(a_rsp_valid), 1);
        chk("a_rr_reclear_rdata", a_rdata, 32'hA5A5_A5A5);

        // B: clear of 12 words, then addr*3 written to 0..7
        @(negedge clk);
        b_rst_n = 1;
        #1;
        repeat (11) @(negedge clk);
        #1;
        chk("b_clr_c12_init_done", 32'(b_init_done), 0);
        for (int a = 0; a < 8; a++) begin
            @(negedge clk);
            b_valid = 1; b_we = 1; b_addr = 4'(a); b_be = 4'hF; b_wdata = 32'(a * 3);
            #1;
            if (a == 0) chk("b_init_done_c13", 32'(b_init_done), 1);
            chk($sformatf("b_wr%0d_ready", a), 32'(b_ready), 1);
        end

        // B: 8 back-to-back reads, responses in cycles N+2..N+9
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k < 8) begin
                b_valid = 1; b_we = 0; b_addr = 4'(k);
            end else begin
                b_valid = 0;
            end
            #1;
            if (k >= 2 && k <= 9) begin
                b_exp = 32'((k - 2) * 3);
                chk($sformatf("b_pipe%0d_valid", k), 32'(b_rsp_valid), 1);
                chk($sformatf("b_pipe%0d_rdata", k), b_rdata, b_exp);
                chk($sformatf("b_pipe%0d_err", k), 32'(b_rsp_err), 0);
            end else begin
                b_exp = (k < 2) ? 32'h0 : 32'd21;
                chk($sformatf("b_pipe%0d_valid", k), 32'(b_rsp_valid), 0);
                chk($sformatf("b_pipe%0d_hold", k), b_rdata, b_exp);
            end
        end

        // B: out-of-range read then last in-range word
        @(negedge clk);
        b_valid = 1; b_we = 0; b_addr = 4'd13;
        #1;
        @(negedge clk);
        b_addr = 4'd11;
        #1;
        chk("b_oor_c1_valid", 32'(b_rsp_valid), 0);
        @(negedge clk);
        b_valid = 0;
        #1;
        chk("b_oor_valid", 32'(b_rsp_valid), 1);
        chk("b_oor_err", 32'(b_rsp_err), 1);
        chk("b_oor_rdata", b_rdata, 32'h0);
        @(negedge clk);
        #1;
        chk("b_last_valid", 32'(b_rsp_valid), 1);
        chk("b_last_err", 32'(b_rsp_err), 0);
        chk("b_last_rdata", b_rdata, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
